// File: rtl/uart_frame_pkg.sv
// Shared constants, state types and hex encoding for the framebuffer UART streamer.
package uart_frame_pkg;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_PLUS = 8'h2B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_DIGITS,
    ST_SEP,
    ST_FIN
  } frame_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  // Uppercase ASCII hex digit; inverse of the loader's hex decode.
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer with a valid/ready input; idle line is high.
module uart_tx_byte
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 27_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_VALID,
  input  logic [7:0] i_DATA,
  output logic       o_READY,
  output logic       o_TX
);

  localparam int unsigned BIT   = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W = (BIT > 1) ? $clog2(BIT) : 1;

  ser_state_t       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_W'(BIT - 1));
  // Ready on the last stop-bit cycle lets the next start bit follow with no gap.
  assign o_READY = (state == SER_IDLE) || ((state == SER_STOP) && bit_end);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= SER_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      o_TX     <= 1'b1;
    end else if (i_VALID && o_READY) begin
      state    <= SER_START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= i_DATA;
      o_TX     <= 1'b0;
    end else begin
      case (state)
        SER_IDLE: begin
          baud_cnt <= '0;
          o_TX     <= 1'b1;
        end
        SER_START: begin
          if (bit_end) begin
            state    <= SER_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_TX     <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        SER_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= SER_STOP;
              o_TX  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_TX    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        SER_STOP: begin
          if (bit_end) begin
            state    <= SER_IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= SER_IDLE;
          o_TX  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Streams the framebuffer out as '#', hex digits per line and '+' separators over 8N1 UART.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 27_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned LINES      = 608,
  parameter int unsigned PIXELS     = 300,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_START,
  output logic [ADDR_W-1:0] o_LINE_ADDR,
  input  logic [PIXELS-1:0] i_LINE_DATA,
  output logic              o_TX,
  output logic              o_BUSY,
  output logic              o_DONE
);

  localparam int unsigned NDIG  = PIXELS / 4;
  localparam int unsigned DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  frame_state_t      state;
  logic [ADDR_W-1:0] line_cnt;
  logic [DIG_W-1:0]  digit_cnt;
  logic [PIXELS-1:0] line_reg;
  logic [PIXELS-1:0] line_next;
  logic              fetch_wait;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              tx_accept;

  assign tx_accept = tx_valid && tx_ready;
  assign line_next = line_reg >> 4;

  uart_tx_byte #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) u_tx (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_VALID (tx_valid),
    .i_DATA  (tx_data),
    .o_READY (tx_ready),
    .o_TX    (o_TX)
  );

  // The next byte is staged while the current one serializes, so the stream never gaps.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= ST_IDLE;
      line_cnt    <= '0;
      digit_cnt   <= '0;
      line_reg    <= '0;
      fetch_wait  <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      o_LINE_ADDR <= '0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_START && !o_DONE) begin
            state    <= ST_HDR;
            o_BUSY   <= 1'b1;
            line_cnt <= '0;
            tx_data  <= CH_HASH;
            tx_valid <= 1'b1;
          end
        end
        ST_HDR, ST_SEP: begin
          if (tx_accept) begin
            state       <= ST_FETCH;
            tx_valid    <= 1'b0;
            o_LINE_ADDR <= line_cnt;
            fetch_wait  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            line_reg  <= i_LINE_DATA;
            tx_data   <= nibble_to_hex(i_LINE_DATA[3:0]);
            tx_valid  <= 1'b1;
            digit_cnt <= '0;
            state     <= ST_DIGITS;
          end
        end
        ST_DIGITS: begin
          if (tx_accept) begin
            line_reg <= line_next;
            if (digit_cnt == DIG_W'(NDIG - 1)) begin
              if (line_cnt == ADDR_W'(LINES - 1)) begin
                tx_valid <= 1'b0;
                state    <= ST_FIN;
              end else begin
                tx_data  <= CH_PLUS;
                line_cnt <= line_cnt + ADDR_W'(1);
                state    <= ST_SEP;
              end
            end else begin
              digit_cnt <= digit_cnt + DIG_W'(1);
              tx_data   <= nibble_to_hex(line_next[3:0]);
            end
          end
        end
        ST_FIN: begin
          // Serializer ready again means the final stop bit is ending this cycle.
          if (tx_ready) begin
            state  <= ST_IDLE;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench: decodes o_TX and compares against a hex-text frame model of the BRAM contents.
module tb_uart_frame_tx;

  localparam int unsigned CLOCK_RATE = 400;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int unsigned LINES      = 2;
  localparam int unsigned PIXELS     = 8;
  localparam int unsigned ADDR_W     = 1;
  localparam int unsigned BIT        = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CHAR_CYC   = 10 * BIT;
  localparam int unsigned NDIG       = PIXELS / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] line_addr;
  logic [PIXELS-1:0] line_data;
  logic              tx;
  logic              busy;
  logic              done;

  logic [PIXELS-1:0] mem [LINES];

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int frame_err = 0;
  bit in_char = 0;
  int pos = 0;
  int cur_start = 0;
  logic [CHAR_CYC-1:0] sh;
  logic [7:0]          rx_q[$];
  int                  st_q[$];
  logic [CHAR_CYC-1:0] raw_q[$];
  int                  held_addr = 0;

  uart_frame_tx #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .LINES      (LINES),
    .PIXELS     (PIXELS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_START     (start),
    .o_LINE_ADDR (line_addr),
    .i_LINE_DATA (line_data),
    .o_TX        (tx),
    .o_BUSY      (busy),
    .o_DONE      (done)
  );

  always #5 clk = ~clk;

  // BRAM read port: data follows the address one cycle later.
  always @(posedge clk) line_data <= mem[line_addr];

  // Line monitor: samples o_TX once per cycle and decodes complete characters.
  always @(negedge clk) begin
    logic [7:0] ch;
    bit bad;
    cyc = cyc + 1;
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (rst) begin
      in_char = 0;
    end else if (!in_char) begin
      if (tx === 1'b0) begin
        in_char   = 1;
        sh        = '0;
        pos       = 1;
        cur_start = cyc;
      end
    end else begin
      sh[pos] = tx;
      pos = pos + 1;
      if (pos == CHAR_CYC) begin
        in_char = 0;
        bad = 0;
        for (int b = 0; b < 10; b++)
          for (int j = 0; j < BIT; j++)
            if (sh[b*BIT+j] !== sh[b*BIT]) bad = 1;
        if (sh[9*BIT] !== 1'b1) bad = 1;
        if (bad) frame_err = frame_err + 1;
        for (int i = 0; i < 8; i++) ch[i] = sh[(i+1)*BIT];
        rx_q.push_back(ch);
        st_q.push_back(cur_start);
        raw_q.push_back(sh);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: '#', NDIG uppercase hex digits per line (low nibble first), '+' between lines.
  function automatic void build_frame(output logic [7:0] q[$]);
    int nib;
    q = {};
    q.push_back(8'h23);
    for (int l = 0; l < LINES; l++) begin
      for (int k = 0; k < NDIG; k++) begin
        nib = int'((mem[l] >> (4*k)) & PIXELS'(15));
        if (nib < 10) q.push_back(8'(48 + nib));
        else          q.push_back(8'(65 + nib - 10));
      end
      if (l < LINES - 1) q.push_back(8'h2B);
    end
  endfunction

  task automatic run_frame(input bit restart_mid, input bit restart_done, input string tag);
    logic [7:0] exp_q[$];
    int exp_addr[$];
    int got_addr[$];
    int base, dbase, c0, n, last;
    bit got_done;
    logic [CHAR_CYC-1:0] exp_raw;
    logic v;

    build_frame(exp_q);
    base  = rx_q.size();
    dbase = done_cnt;
    exp_addr = {held_addr};
    for (int l = 0; l < LINES; l++)
      if (exp_addr[$] != l) exp_addr.push_back(l);

    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, busy, 0);
    got_addr.push_back(int'(line_addr));
    start = 1'b1;
    c0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);

    got_done = 0;
    for (int i = 0; i < 20 * CHAR_CYC && !got_done; i++) begin
      if (int'(line_addr) != got_addr[$]) got_addr.push_back(int'(line_addr));
      if (done === 1'b1) begin
        got_done = 1;
      end else begin
        start = restart_mid && (i == 100);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);

    if (restart_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (restart_done) chk({tag, "_start_on_done_ignored"}, busy, 0);
    repeat (CHAR_CYC + 5) @(posedge clk);
    #1;

    n = rx_q.size() - base;
    chk({tag, "_char_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_char%0d", tag, i), rx_q[base+i], exp_q[i]);
    for (int i = 1; i < n; i++)
      chk($sformatf("%s_gap%0d", tag, i), st_q[base+i] - st_q[base+i-1], CHAR_CYC);
    if (n > 0) begin
      chk({tag, "_start_latency_ok"}, (st_q[base] - c0 >= 1) && (st_q[base] - c0 <= 4), 1);
      for (int b = 0; b < 10; b++) begin
        v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_q[0][b-1];
        for (int j = 0; j < BIT; j++) exp_raw[b*BIT+j] = v;
      end
      chk({tag, "_first_char_bits"}, raw_q[base], exp_raw);
      last = st_q[base+n-1];
      chk({tag, "_done_timing"}, done_cyc, last + CHAR_CYC);
    end
    chk({tag, "_done_count"}, done_cnt - dbase, 1);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_addr_seq_len"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
    chk({tag, "_addr_hold"}, line_addr, LINES - 1);
    chk({tag, "_busy_end"}, busy, 0);
    held_addr = LINES - 1;
  endtask

  initial begin
    int base, dbase, dseen;
    rst   = 1'b1;
    start = 1'b0;
    for (int l = 0; l < LINES; l++) mem[l] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", line_addr, 0);
    rst = 1'b0;
    held_addr = 0;

    mem[0] = 8'hA5; mem[1] = 8'h3C;
    run_frame(0, 0, "basic");

    mem[0] = 8'h9A; mem[1] = 8'h0F;
    run_frame(0, 0, "hexedge");

    for (int l = 0; l < LINES; l++) mem[l] = PIXELS'($urandom);
    run_frame(1, 1, "restart");
    run_frame(0, 0, "repeat");

    // Reset during the third character's data bits.
    for (int l = 0; l < LINES; l++) mem[l] = PIXELS'($urandom);
    base  = rx_q.size();
    dbase = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * CHAR_CYC + 14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", line_addr, 0);
    dseen = 0;
    for (int i = 0; i < 3 * CHAR_CYC; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || tx !== 1'b1) dseen++;
    end
    chk("midrst_quiet", dseen, 0);
    chk("midrst_no_done", done_cnt - dbase, 0);
    chk("midrst_partial_chars", rx_q.size() - base, 2);
    held_addr = 0;
    run_frame(0, 0, "after_rst");

    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < LINES; l++) mem[l] = PIXELS'($urandom);
      run_frame(0, 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Reads the framebuffer line by line and streams it out as a hex-text UART character stream, 8N1, idle high.
- The stream uses the same character protocol the board's UART loader consumes:
  - '#' resets the receiver to line 0.
  - Uppercase hex digits carry 4 pixels each.
  - '+' advances to the next line.
- Sits on the 27 MHz domain beside the framebuffer BRAM read port. Used for readback/debug and for board-to-board framebuffer copy.

Parameters:
- CLOCK_RATE, 27_000_000, i_CLK frequency in Hz
- BAUD_RATE, 115200, UART bit rate; bit period BIT = CLOCK_RATE/BAUD_RATE cycles (integer division, must be ≥2)
- LINES, 608, framebuffer lines sent per frame
- PIXELS, 300, pixels per line; must be a multiple of 4; NDIG = PIXELS/4 digits per line
- ADDR_W, 10, line address width; 2^ADDR_W ≥ LINES

Ports:
- i_CLK  in  1  system clock (27 MHz)
- i_RST  in  1  synchronous, active-high reset
- i_START  in  1  single-cycle request to send one full frame
- o_LINE_ADDR  out  ADDR_W  BRAM read address (registered)
- i_LINE_DATA  in  PIXELS  BRAM read data, valid 1 cycle after o_LINE_ADDR changes
- o_TX  out  1  UART serial output
- o_BUSY  out  1  high from the cycle after an accepted i_START until the last stop bit ends
- o_DONE  out  1  one-cycle pulse on the cycle o_BUSY falls

Behaviour:
- Reset values: o_TX=1, o_BUSY=0, o_DONE=0, o_LINE_ADDR=0. The top FSM and the serializer both return to IDLE.
- Reset mid-frame: o_TX=1 the next cycle; the partial character is abandoned; no o_DONE is produced.
- Frame stream, in order:
  - '#'
  - For each line L = 0..LINES-1: NDIG digits, then '+' if L < LINES-1.
  - No trailing '+'. Total characters = 1 + LINES*NDIG + (LINES-1).
- Digit encoding:
  - Digit k (k = 0..NDIG-1, sent in increasing k) = bits [4k+3:4k] of the line word.
  - Values 0-9 map to ASCII 0x30-0x39; values A-F map to 0x41-0x46 (uppercase only).
- Character framing:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly BIT cycles, so a character takes 10*BIT cycles.
  - Consecutive characters within a frame are back-to-back: the next start bit begins on the cycle after the previous stop bit ends.
- Top FSM states:
  - IDLE: wait for i_START.
  - HDR: send '#'.
  - FETCH: drive o_LINE_ADDR=L; on the following cycle latch i_LINE_DATA into the line register.
  - DIGITS: send NDIG characters from the line register, shifting it right 4 per digit.
  - SEP: send '+'.
  - FIN: pulse o_DONE, return to IDLE.
- Prefetch rule: the FETCH for line L (2 cycles) overlaps serialization of the preceding '#' or '+'. The line register updates only after the last digit of line L-1 has been handed to the serializer. No inter-character gap is allowed.
- Start handling:
  - i_START in IDLE is accepted on that edge.
  - First start bit (o_TX=0) appears at most 4 cycles after acceptance.
  - i_START while o_BUSY=1 is ignored.
  - i_START asserted on the same cycle o_DONE pulses is ignored.
- Line counter: ADDR_W bits, counts 0..LINES-1, never wraps within a frame. o_LINE_ADDR holds its last value when idle.
- Baud counter: counts 0..BIT-1 and restarts on each bit. No fractional-baud accumulation.
- Serializer handshake: valid/ready. A byte is accepted only when both are high; ready is high only in the serializer's IDLE state or on the final stop-bit cycle.

Decomposition:
- Shared package uart_frame_pkg:
  - ASCII constants CH_HASH=8'h23, CH_PLUS=8'h2B.
  - Function nibble_to_hex (4-bit to uppercase ASCII), the inverse of the loader's hex decode.
  - Top-FSM state enum.
- Sub-module uart_tx_byte: 8N1 serializer with parameters CLOCK_RATE/BAUD_RATE, ports i_CLK, i_RST, i_VALID, i_DATA[7:0], o_READY, o_TX.
- uart_frame_tx instantiates it and owns the FSM, line register, digit counter and line counter.

Test Plan:
(Benches use CLOCK_RATE=400, BAUD_RATE=100 (BIT=4), LINES=2, PIXELS=8 unless noted.)
- Basic frame: BRAM line0=8'hA5, line1=8'h3C; pulse i_START. Decoded o_TX must be 0x23,0x35,0x41,0x2B,0x43,0x33 ("#5A+C3"), with no gaps between characters. o_DONE pulses once, 1 cycle after the last stop bit.
- Bit timing: on the first character, measure o_TX. Start bit low for exactly 4 cycles, data 0x23 LSB first (1,1,0,0,0,1,0,0), stop bit high for 4 cycles.
- Busy re-start: pulse i_START again mid-frame and on the o_DONE cycle. Exactly 6 characters are produced, and a subsequent i_START produces a second identical frame.
- Read latency: bench BRAM model changes i_LINE_DATA only 1 cycle after o_LINE_ADDR. Digits must match the addressed line; o_LINE_ADDR sequence is 0 then 1.
- Reset mid-frame: assert i_RST during the 3rd character's data bits. Next cycle o_TX=1, o_BUSY=0; no o_DONE. A new i_START sends the full frame from '#'.
- Default parameters: CLOCK_RATE=27e6, BAUD_RATE=115200, LINES=608, PIXELS=300, all-ones BRAM. Exactly 1+608*75+607=46208 characters, BIT=234; every digit character is 'F'.
